// File: rtl/scalar_wb_ctl.sv
// Scalar writeback and reservation controller for the S register file.
// Tracks add/logical/shift results to a single S write port.
module scalar_wb_ctl #(
  parameter int ADD_LAT = 3,
  parameter int LOG_LAT = 1,
  parameter int SHF_LAT = 2,
  parameter int MAX_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_issue,
  input  logic [1:0]  i_fu,
  input  logic [2:0]  i_dest,
  input  logic [2:0]  i_src_j,
  input  logic [2:0]  i_src_k,
  input  logic [63:0] i_add_res,
  input  logic [63:0] i_log_res,
  input  logic [63:0] i_shf_res,
  output logic        o_issue_ok,
  output logic [7:0]  o_busy,
  output logic        o_we,
  output logic [2:0]  o_waddr,
  output logic [63:0] o_wdata
);

  localparam logic [1:0] FU_ADD = 2'b00;
  localparam logic [1:0] FU_LOG = 2'b01;
  localparam logic [1:0] FU_SHF = 2'b10;

  typedef struct packed {
    logic       v;
    logic [2:0] dest;
    logic [1:0] fu;
  } ent_t;

  ent_t pipe_q [MAX_LAT];
  ent_t pipe_d [MAX_LAT];

  int   lat;
  logic coll;
  logic accept;

  // latency of the unit being requested
  always_comb begin
    lat = MAX_LAT;
    unique case (1'b1)
      (i_fu == FU_ADD): lat = ADD_LAT;
      (i_fu == FU_LOG): lat = LOG_LAT;
      (i_fu == FU_SHF): lat = SHF_LAT;
      default:          lat = MAX_LAT;
    endcase
  end

  // reservation bits and writeback-slot collision, both from pre-edge pipe
  always_comb begin
    o_busy = '0;
    coll   = 1'b0;
    for (int n = 0; n < MAX_LAT; n++) begin
      if (pipe_q[n].v) o_busy[pipe_q[n].dest] = 1'b1;
      if (n == lat) coll = coll | pipe_q[n].v;
    end
  end

  // issue gating: valid unit, no register hazard, free writeback slot
  always_comb begin
    o_issue_ok = (i_fu != 2'b11) &&
                 !o_busy[i_dest] &&
                 !o_busy[i_src_j] &&
                 !o_busy[i_src_k] &&
                 !coll;
    accept = i_issue && o_issue_ok && rst;
  end

  // next pipe: shift down one slot, new issue lands at its latency slot
  always_comb begin
    for (int n = 0; n < MAX_LAT - 1; n++) begin
      pipe_d[n] = pipe_q[n+1];
    end
    pipe_d[MAX_LAT-1] = '0;
    for (int n = 0; n < MAX_LAT; n++) begin
      if (accept && (n == lat - 1)) begin
        pipe_d[n] = '{v: 1'b1, dest: i_dest, fu: i_fu};
      end
    end
  end

  // tracking pipe register; reset drops every in-flight result
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int n = 0; n < MAX_LAT; n++) pipe_q[n] <= '0;
    end else begin
      for (int n = 0; n < MAX_LAT; n++) pipe_q[n] <= pipe_d[n];
    end
  end

  // writeback port driven from the bottom slot, zeroed when idle
  always_comb begin
    o_we    = pipe_q[0].v;
    o_waddr = '0;
    o_wdata = '0;
    if (pipe_q[0].v) begin
      o_waddr = pipe_q[0].dest;
      unique case (1'b1)
        (pipe_q[0].fu == FU_ADD): o_wdata = i_add_res;
        (pipe_q[0].fu == FU_LOG): o_wdata = i_log_res;
        (pipe_q[0].fu == FU_SHF): o_wdata = i_shf_res;
        default:                  o_wdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_wb_ctl.sv
// Directed bench for scalar_wb_ctl.
// Inputs change 1 after posedge; outputs sampled 2 later.
module tb_scalar_wb_ctl;

  logic        clk;
  logic        rst;
  logic        i_issue;
  logic [1:0]  i_fu;
  logic [2:0]  i_dest;
  logic [2:0]  i_src_j;
  logic [2:0]  i_src_k;
  logic [63:0] i_add_res;
  logic [63:0] i_log_res;
  logic [63:0] i_shf_res;
  logic        o_issue_ok;
  logic [7:0]  o_busy;
  logic        o_we;
  logic [2:0]  o_waddr;
  logic [63:0] o_wdata;

  int n_cmp;
  int n_err;

  localparam logic [63:0] ADD_V = 64'hA0A0_1111_2222_3333;
  localparam logic [63:0] LOG_V = 64'hB0B0_4444_5555_6666;
  localparam logic [63:0] SHF_V = 64'hC0C0_7777_8888_9999;

  scalar_wb_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .i_issue    (i_issue),
    .i_fu       (i_fu),
    .i_dest     (i_dest),
    .i_src_j    (i_src_j),
    .i_src_k    (i_src_k),
    .i_add_res  (i_add_res),
    .i_log_res  (i_log_res),
    .i_shf_res  (i_shf_res),
    .o_issue_ok (o_issue_ok),
    .o_busy     (o_busy),
    .o_we       (o_we),
    .o_waddr    (o_waddr),
    .o_wdata    (o_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic iss, input logic [1:0] fu,
                       input logic [2:0] d, input logic [2:0] j,
                       input logic [2:0] k);
    i_issue = iss;
    i_fu    = fu;
    i_dest  = d;
    i_src_j = j;
    i_src_k = k;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 2'b00, 3'd1, 3'd0, 3'd0);
    tick();
    drive(1'b1, 2'b00, 3'd1, 3'd0, 3'd0);
    tick();
    drive(1'b0, 2'b00, 3'd0, 3'd0, 3'd0);
    n_cmp++;
    if (o_busy !== 8'h00 || o_we !== 1'b0 ||
        o_waddr !== 3'd0 || o_wdata !== 64'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%h we=%b waddr=%0d wdata=%h want 0",
               o_busy, o_we, o_waddr, o_wdata);
    end
    rst = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      drive(1'b0, 2'(f), 3'd2, 3'd3, 3'd4);
      n_cmp++;
      if (o_issue_ok !== 1'b1) begin
        n_err++;
        $display("FAIL reset_release_ok fu=%0d: got %b want 1",
                 f, o_issue_ok);
      end
    end
    n_cmp++;
    if (o_busy !== 8'h00 || o_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_state: busy=%h we=%b want 00/0",
               o_busy, o_we);
    end
  endtask

  task automatic test_add_dependent();
    drive(1'b1, 2'b00, 3'd2, 3'd3, 3'd4);
    n_cmp++;
    if (o_issue_ok !== 1'b1) begin
      n_err++;
      $display("FAIL add_issue_ok: got %b want 1", o_issue_ok);
    end
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(1'b1, 2'b00, 3'd7, 3'd2, 3'd0);
      n_cmp++;
      if (o_busy !== 8'h04 || o_issue_ok !== 1'b0) begin
        n_err++;
        $display("FAIL add_busy c%0d: busy=%h ok=%b want 04/0",
                 c, o_busy, o_issue_ok);
      end
      n_cmp++;
      if (c == 3) begin
        if (o_we !== 1'b1 || o_waddr !== 3'd2 || o_wdata !== ADD_V) begin
          n_err++;
          $display("FAIL add_write c3: we=%b waddr=%0d wdata=%h want 1/2/%h",
                   o_we, o_waddr, o_wdata, ADD_V);
        end
      end else if (o_we !== 1'b0 || o_wdata !== 64'd0) begin
        n_err++;
        $display("FAIL add_nowrite c%0d: we=%b wdata=%h want 0/0",
                 c, o_we, o_wdata);
      end
      tick();
    end
    drive(1'b1, 2'b00, 3'd7, 3'd2, 3'd0);
    n_cmp++;
    if (o_busy !== 8'h00 || o_issue_ok !== 1'b1 || o_we !== 1'b0) begin
      n_err++;
      $display("FAIL dep_accept c4: busy=%h ok=%b we=%b want 00/1/0",
               o_busy, o_issue_ok, o_we);
    end
    tick();
    for (int c = 5; c <= 7; c++) begin
      drive(1'b0, 2'b00, 3'd0, 3'd0, 3'd0);
      n_cmp++;
      if (o_busy !== 8'h80 || o_we !== (c == 7) ||
          o_waddr !== ((c == 7) ? 3'd7 : 3'd0)) begin
        n_err++;
        $display("FAIL dep_pipe c%0d: busy=%h we=%b waddr=%0d",
                 c, o_busy, o_we, o_waddr);
      end
      tick();
    end
    drive(1'b0, 2'b00, 3'd0, 3'd0, 3'd0);
    n_cmp++;
    if (o_busy !== 8'h00 || o_we !== 1'b0) begin
      n_err++;
      $display("FAIL dep_clear: busy=%h we=%b want 00/0", o_busy, o_we);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 2'b00, 3'd1, 3'd0, 3'd0);
    n_cmp++;
    if (o_issue_ok !== 1'b1) begin
      n_err++;
      $display("FAIL coll_add_ok: got %b want 1", o_issue_ok);
    end
    tick();
    drive(1'b1, 2'b10, 3'd5, 3'd0, 3'd0);
    n_cmp++;
    if (o_issue_ok !== 1'b0) begin
      n_err++;
      $display("FAIL coll_shf c1: ok=%b want 0", o_issue_ok);
    end
    tick();
    drive(1'b1, 2'b01, 3'd5, 3'd0, 3'd0);
    n_cmp++;
    if (o_issue_ok !== 1'b0) begin
      n_err++;
      $display("FAIL coll_log c2: ok=%b want 0", o_issue_ok);
    end
    tick();
    drive(1'b1, 2'b01, 3'd5, 3'd0, 3'd0);
    n_cmp++;
    if (o_issue_ok !== 1'b1 || o_busy !== 8'h02 ||
        o_we !== 1'b1 || o_waddr !== 3'd1 || o_wdata !== ADD_V) begin
      n_err++;
      $display("FAIL coll_c3: ok=%b busy=%h we=%b waddr=%0d wdata=%h",
               o_issue_ok, o_busy, o_we, o_waddr, o_wdata);
    end
    tick();
    drive(1'b0, 2'b00, 3'd0, 3'd0, 3'd0);
    n_cmp++;
    if (o_busy !== 8'h20 || o_we !== 1'b1 ||
        o_waddr !== 3'd5 || o_wdata !== LOG_V) begin
      n_err++;
      $display("FAIL coll_log_write c4: busy=%h we=%b waddr=%0d wdata=%h",
               o_busy, o_we, o_waddr, o_wdata);
    end
    tick();
    drive(1'b0, 2'b00, 3'd0, 3'd0, 3'd0);
    n_cmp++;
    if (o_busy !== 8'h00 || o_we !== 1'b0) begin
      n_err++;
      $display("FAIL coll_clear: busy=%h we=%b want 00/0", o_busy, o_we);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_busy [7];
    logic       exp_we   [7];
    logic [2:0] exp_wa   [7];
    exp_busy = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h06, 8'h04, 8'h00};
    exp_we   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_wa   = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd0};
    for (int c = 0; c < 7; c++) begin
      if (c < 3) drive(1'b1, 2'b00, 3'(c), 3'd3, 3'd4);
      else       drive(1'b0, 2'b00, 3'd0, 3'd0, 3'd0);
      n_cmp++;
      if (o_busy !== exp_busy[c] || o_we !== exp_we[c] ||
          o_waddr !== exp_wa[c] ||
          o_wdata !== (exp_we[c] ? ADD_V : 64'd0) ||
          (c < 3 && o_issue_ok !== 1'b1)) begin
        n_err++;
        $display("FAIL b2b c%0d: busy=%h we=%b waddr=%0d ok=%b want %h/%b/%0d",
                 c, o_busy, o_we, o_waddr, o_issue_ok,
                 exp_busy[c], exp_we[c], exp_wa[c]);
      end
      tick();
    end
  endtask

  task automatic test_invalid_fu();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 2'b11, 3'd3, 3'd1, 3'd2);
      n_cmp++;
      if (o_issue_ok !== 1'b0 || o_busy !== 8'h00 || o_we !== 1'b0) begin
        n_err++;
        $display("FAIL invalid_fu c%0d: ok=%b busy=%h we=%b want 0/00/0",
                 c, o_issue_ok, o_busy, o_we);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'b00, 3'd6, 3'd0, 3'd1);
    n_cmp++;
    if (o_issue_ok !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_issue: ok=%b want 1", o_issue_ok);
    end
    tick();
    drive(1'b0, 2'b00, 3'd0, 3'd0, 3'd0);
    n_cmp++;
    if (o_busy !== 8'h40) begin
      n_err++;
      $display("FAIL rmid_busy c1: got %h want 40", o_busy);
    end
    tick();
    rst = 1'b0;
    drive(1'b1, 2'b00, 3'd3, 3'd0, 3'd0);
    n_cmp++;
    if (o_busy !== 8'h40 || o_we !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_c2: busy=%h we=%b want 40/0", o_busy, o_we);
    end
    tick();
    rst = 1'b1;
    drive(1'b0, 2'b00, 3'd6, 3'd0, 3'd1);
    n_cmp++;
    if (o_busy !== 8'h00 || o_we !== 1'b0 || o_issue_ok !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_c3: busy=%h we=%b ok=%b want 00/0/1",
               o_busy, o_we, o_issue_ok);
    end
    tick();
    for (int c = 4; c <= 7; c++) begin
      drive(1'b0, 2'b00, 3'd0, 3'd0, 3'd0);
      n_cmp++;
      if (o_we !== 1'b0 || o_busy !== 8'h00) begin
        n_err++;
        $display("FAIL rmid_nowrite c%0d: we=%b busy=%h want 0/00",
                 c, o_we, o_busy);
      end
      tick();
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b0;
    i_issue   = 1'b0;
    i_fu      = 2'b00;
    i_dest    = 3'd0;
    i_src_j   = 3'd0;
    i_src_k   = 3'd0;
    i_add_res = ADD_V;
    i_log_res = LOG_V;
    i_shf_res = SHF_V;
    @(posedge clk);
    #1;
    test_reset();
    test_add_dependent();
    tick();
    test_collision();
    tick();
    test_back_to_back();
    test_invalid_fu();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scalar_wb_ctl.md
Name: scalar_wb_ctl

Overview:
- Scalar writeback and reservation controller for the S register file.
- Accepts instruction issue for the scalar add (060/061), scalar logical and scalar shift units.
- Tracks each destination S register through its unit's fixed latency, and blocks issue on register hazards and writeback-port collisions.
- Muxes the completing unit's 64-bit result onto the single S-register write port in the cycle that result becomes valid.

Parameters:
ADD_LAT, 3, clocks from issue cycle to scalar add result valid
LOG_LAT, 1, clocks from issue cycle to scalar logical result valid
SHF_LAT, 2, clocks from issue cycle to scalar shift result valid
MAX_LAT, 3, tracking pipe depth; must be >= every *_LAT; every *_LAT >= 1

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous reset, active-low
i_issue  input  1  issue request this cycle
i_fu  input  2  unit select: 00 add, 01 logical, 10 shift, 11 invalid
i_dest  input  3  destination Si
i_src_j  input  3  operand Sj
i_src_k  input  3  operand Sk
i_add_res  input  64  scalar add unit result
i_log_res  input  64  scalar logical unit result
i_shf_res  input  64  scalar shift unit result
o_issue_ok  output  1  issue permitted this cycle (combinational)
o_busy  output  8  per-S-register reservation
o_we  output  1  S register file write enable
o_waddr  output  3  write address
o_wdata  output  64  write data

Behaviour:
- Tracking pipe: MAX_LAT entries pipe[0..MAX_LAT-1], each entry {valid, dest[2:0], fu[1:0]}.
- Shift rule: every posedge, pipe[n] <= pipe[n+1]; the top entry loads invalid unless written by an issue.
- Issue acceptance: issue is accepted when i_issue && o_issue_ok. Let L be the selected unit's latency.
  - On the same edge, pipe[L-1] <= {1, i_dest, i_fu}, which overrides the shift into that slot.
- o_issue_ok = 1 only if all of the following hold:
  - i_fu != 11;
  - o_busy[i_dest], o_busy[i_src_j] and o_busy[i_src_k] are all 0;
  - no collision: L < MAX_LAT and pipe[L].valid counts as a collision. L = MAX_LAT never collides.
- o_busy[r] is the OR over n of (pipe[n].valid && pipe[n].dest == r). It is combinational from pipe state.
- No bypass:
  - A register being written this cycle (pipe[0]) is still busy.
  - Dependent issue waits one cycle after o_we.
- Writeback:
  - o_we = pipe[0].valid; o_waddr = pipe[0].dest.
  - o_wdata = i_add_res, i_log_res or i_shf_res, selected by pipe[0].fu.
  - o_wdata = 0 and o_waddr = 0 when o_we = 0.
- Timing: an add issued in cycle t gives o_we = 1 in cycle t+3, matching add operands presented in cycle t.
  - The reservation clears at the edge ending cycle t+3.
- Throughput: at most one issue per cycle and at most one writeback per cycle, guaranteed by the collision check.
- Simultaneous events: an issue whose slot is vacated by the same edge's shift is legal. The collision check uses pre-edge pipe[L], which is exactly the entry landing in slot L-1.
- i_issue with o_issue_ok = 0: ignored, no state change. The requester holds and retries.
- Reset (rst = 0 at posedge):
  - all pipe entries invalid;
  - o_we = 0, o_waddr = 0, o_wdata = 0, o_busy = 0;
  - in-flight results are discarded and never written.
- Reset mid-operation has the same effect. Issue during reset is ignored.
- First cycle after reset release: o_issue_ok = 1 for any valid fu.

Test Plan:
- Reset then add issue (i_fu=00, dest=S2, j=S3, k=S4) at cycle 0 -> o_busy=8'h04 in cycles 1-3; o_we=1, o_waddr=2, o_wdata=i_add_res only in cycle 3; o_busy=0 in cycle 4.
- Dependent add needing S2 presented every cycle from cycle 1 after the above -> o_issue_ok=0 in cycles 1-3, accepted in cycle 4, write in cycle 7.
- Collision: add issued cycle 0 (dest S1), logical issued cycle 2 (dest S5) -> o_issue_ok=0 at cycle 2. Shift issued cycle 1 (dest S5) -> also blocked (pipe[2] valid at cycle 1). Logical at cycle 3 -> accepted, write S5 in cycle 4 with i_log_res.
- Back-to-back: adds to S0, S1, S2 in cycles 0, 1, 2 -> writes in cycles 3, 4, 5 with waddr 0, 1, 2; o_busy peaks 8'h07.
- i_fu=11 with i_issue=1 -> o_issue_ok=0, o_busy unchanged, no write ever.
- Reset asserted in cycle 2 after add to S6 at cycle 0 -> o_we never asserts; o_busy=0 from cycle 3; o_issue_ok=1 after release.
